// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit
//   Decode-stage hazard detector that sits directly upstream of the control unit.
//   - Detects a load-use hazard between the instruction in ID and a load in EX,
//     and inserts one bubble for each hazard.
//   - Freezes fetch and bubbles ID while a BEQ resolves (state BR_WAIT).
//   - Counts stall cycles in a saturating counter.
//
// Ports
//   clk             in   1      rising-edge clock
//   reset           in   1      asynchronous, active-high reset
//   id_opcode       in   6      opcode of the instruction in ID
//   id_rs, id_rt    in   5      source register fields of the instruction in ID
//   ex_mem_read     in   1      the instruction in EX is a load
//   ex_rt           in   5      destination register of the load in EX
//   branch_resolved in   1      pulse: the pending BEQ outcome is known
//   stall_flag      out  1      to the control unit: hold the current control outputs
//   pc_write        out  1      PC write enable
//   if_id_write     out  1      IF/ID write enable
//   if_id_flush     out  1      clear IF/ID to a NOP
//   id_ex_flush     out  1      load a bubble into ID/EX
//   stall_count     out  CNT_W  number of cycles with stall_flag=1, saturating
//   dbg_state       out  1      current FSM state (0 = RUN, 1 = BR_WAIT)
module hazard_detect_unit #(
   parameter int BR_LATENCY = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       id_opcode,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             branch_resolved,
   output logic             stall_flag,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [CNT_W-1:0] stall_count,
   output logic             dbg_state
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b000001;
   localparam logic [5:0] OP_SW    = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000011;
   localparam logic [5:0] OP_ADDI  = 6'b000100;

   localparam logic [3:0] BR_LOAD = 4'(BR_LATENCY - 1);

   typedef enum logic {
      RUN     = 1'b0,
      BR_WAIT = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] br_cnt_q, br_cnt_d;

   logic uses_rs, uses_rt, load_use, is_beq;

   // Which source registers the instruction in ID actually reads.
   always_comb begin
      uses_rs = 1'b0;
      uses_rt = 1'b0;
      case (id_opcode)
         OP_RTYPE, OP_SW, OP_BEQ: begin
            uses_rs = 1'b1;
            uses_rt = 1'b1;
         end
         OP_LW, OP_ADDI: uses_rs = 1'b1;
         default: ;
      endcase
   end

   // Register 0 is hard-wired, so a load "to r0" can never be a dependency.
   assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                     ((uses_rs && (ex_rt == id_rs)) || (uses_rt && (ex_rt == id_rt)));
   assign is_beq   = (id_opcode == OP_BEQ);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= RUN;
         br_cnt_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         br_cnt_q <= br_cnt_d;
      end
   end

   // Next-state logic. A load-use hazard outranks BEQ: the BEQ waits in ID
   // and enters BR_WAIT on a later hazard-free cycle.
   always_comb begin
      state_d  = state_q;
      br_cnt_d = br_cnt_q;
      case (state_q)
         RUN: begin
            if (!load_use && is_beq) begin
               state_d  = BR_WAIT;
               br_cnt_d = BR_LOAD;
            end
         end
         BR_WAIT: begin
            if (branch_resolved || (br_cnt_q == 4'd0)) begin
               state_d = RUN;
            end else begin
               br_cnt_d = br_cnt_q - 4'd1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Output logic (Mealy). Reset overrides combinationally so the pipeline is
   // flushed immediately, without waiting for a clock edge.
   always_comb begin
      stall_flag  = 1'b0;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      if (reset) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (state_q == BR_WAIT) begin
         stall_flag  = 1'b1;
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         stall_flag  = 1'b1;
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end else if (is_beq) begin
         // The slot after BEQ is not fetched.
         pc_write = 1'b0;
      end
   end

   // Saturating stall-cycle counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count <= '0;
      end else if (stall_flag && (stall_count != {CNT_W{1'b1}})) begin
         stall_count <= stall_count + 1'b1;
      end
   end

   assign dbg_state = state_q;

endmodule
